multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl_wait_timer.sv | 28 ++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RISC-V sequencer: FSM states, trap causes,
// the latched control word and the opcode decode table.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  // CLS_NONE doubles as the "illegal opcode" marker and the post-reset value.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } instr_class_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [1:0]   alu_op;
    logic [4:0]   imm_type;
    logic         imm_to_alu;
    logic         mem_to_reg;
    instr_class_t cls;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '{
    alu_op: 2'b00, imm_type: 5'b00000, imm_to_alu: 1'b0, mem_to_reg: 1'b0, cls: CLS_NONE
  };

  function automatic ctrl_word_t decode_opcode(input logic [6:0] opcode);
    ctrl_word_t cw;
    cw = CW_NONE;
    case (opcode)
      OP_IMM: begin
        cw.alu_op = 2'b11; cw.imm_type = 5'b00001; cw.imm_to_alu = 1'b1; cw.cls = CLS_ALU;
      end
      OP_REG: begin
        cw.alu_op = 2'b10; cw.imm_type = 5'b00000; cw.cls = CLS_ALU;
      end
      OP_STORE: begin
        cw.alu_op = 2'b00; cw.imm_type = 5'b00010; cw.imm_to_alu = 1'b1; cw.cls = CLS_STORE;
      end
      OP_LOAD: begin
        cw.alu_op = 2'b00; cw.imm_type = 5'b00001; cw.imm_to_alu = 1'b1;
        cw.mem_to_reg = 1'b1; cw.cls = CLS_LOAD;
      end
      OP_BRANCH: begin
        cw.alu_op = 2'b01; cw.imm_type = 5'b00100; cw.cls = CLS_BRANCH;
      end
      default: cw = CW_NONE;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The master side is the sequencer.
interface multicycle_ctrl_if;
  logic [6:0] iOpcode;
  logic       iZero;
  logic       iMemReady;
  logic       oMemReq;
  logic       oMemSel;
  logic       oMemWrite;
  logic       oIRWrite;
  logic       oPCWrite;
  logic       oPCSrc;
  logic       oRegWrite;
  logic       oMemToReg;
  logic       oImmToALU;
  logic [1:0] oALUop;
  logic [4:0] oImmType;
  logic       oRetire;
  logic       oTrap;
  logic [1:0] oTrapCause;
  logic [2:0] oState;

  modport master (
    input  iOpcode, iZero, iMemReady,
    output oMemReq, oMemSel, oMemWrite, oIRWrite, oPCWrite, oPCSrc, oRegWrite,
           oMemToReg, oImmToALU, oALUop, oImmType, oRetire, oTrap, oTrapCause, oState
  );

  modport slave (
    output iOpcode, iZero, iMemReady,
    input  oMemReq, oMemSel, oMemWrite, oIRWrite, oPCWrite, oPCSrc, oRegWrite,
           oMemToReg, oImmToALU, oALUop, oImmType, oRetire, oTrap, oTrapCause, oState
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags when the
// configured limit has been reached.
module wait_timer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_reg;

  assign expired = (count_reg == 8'(MEM_TIMEOUT));

  // Holds at the limit; the sequencer leaves the wait state on that cycle anyway.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= 8'd0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with traps on illegal opcodes and memory timeouts.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               iClk,
  input  logic               iReset,
  multicycle_ctrl_if.master  bus
);

  state_t      state_reg, state_next;
  ctrl_word_t  cw_reg, cw_next;
  trap_cause_t cause_reg, cause_next;
  logic        trap_reg;

  logic mem_req, mem_sel, mem_write, ir_write, pc_write, pc_src, reg_write, retire;
  logic timer_clr, timer_en, timer_expired;

  wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (iClk),
    .srst    (iReset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Only cycles that actually hold a request and see no ready count as waits.
  assign timer_en  = mem_req && !bus.iMemReady;
  assign timer_clr = ((state_next == ST_FETCH) || (state_next == ST_MEM)) &&
                     (state_next != state_reg);

  always_comb begin
    state_next = state_reg;
    cw_next    = cw_reg;
    cause_next = cause_reg;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.iMemReady) begin
          ir_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timer_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      ST_DECODE: begin
        cw_next = decode_opcode(bus.iOpcode);
        if (cw_next.cls == CLS_NONE) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cw_reg.cls)
          CLS_ALU:              state_next = ST_WB;
          CLS_LOAD, CLS_STORE:  state_next = ST_MEM;
          CLS_BRANCH: begin
            pc_write   = 1'b1;
            pc_src     = bus.iZero;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          default: begin
            state_next = ST_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        mem_sel   = 1'b1;
        mem_write = (cw_reg.cls == CLS_STORE);
        if (bus.iMemReady) begin
          if (cw_reg.cls == CLS_STORE) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timer_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end

      ST_TRAP: begin
        state_next = ST_TRAP;
      end

      default: begin
        state_next = ST_TRAP;
        cause_next = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_reg <= ST_FETCH;
      cw_reg    <= CW_NONE;
      cause_reg <= CAUSE_NONE;
      trap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cw_reg    <= cw_next;
      cause_reg <= cause_next;
      trap_reg  <= trap_reg || (state_next == ST_TRAP);
    end
  end

  // Reset blanks every output so a half-finished instruction commits nothing.
  always_comb begin
    bus.oMemReq    = 1'b0;
    bus.oMemSel    = 1'b0;
    bus.oMemWrite  = 1'b0;
    bus.oIRWrite   = 1'b0;
    bus.oPCWrite   = 1'b0;
    bus.oPCSrc     = 1'b0;
    bus.oRegWrite  = 1'b0;
    bus.oMemToReg  = 1'b0;
    bus.oImmToALU  = 1'b0;
    bus.oALUop     = 2'b00;
    bus.oImmType   = 5'b00000;
    bus.oRetire    = 1'b0;
    bus.oTrap      = 1'b0;
    bus.oTrapCause = 2'b00;
    bus.oState     = 3'd0;
    if (!iReset) begin
      bus.oMemReq    = mem_req;
      bus.oMemSel    = mem_sel;
      bus.oMemWrite  = mem_write;
      bus.oIRWrite   = ir_write;
      bus.oPCWrite   = pc_write;
      bus.oPCSrc     = pc_src;
      bus.oRegWrite  = reg_write;
      bus.oMemToReg  = cw_reg.mem_to_reg;
      bus.oImmToALU  = cw_reg.imm_to_alu;
      bus.oALUop     = cw_reg.alu_op;
      bus.oImmType   = cw_reg.imm_type;
      bus.oRetire    = retire;
      bus.oTrap      = trap_reg;
      bus.oTrapCause = cause_reg;
      bus.oState     = state_reg;
    end
  end

endmodule
